reg_bank_32x32_wr: RTL and testbench
====================================

# reg_bank_32x32_wr

Write side and storage of the ezRISC general-purpose register file: 32 registers of REG_SIZE bits, with one synchronous write port addressed by a 5-bit destination index. All 32 register values are driven out on individual ports r0..r31 that feed the 32-to-1 read multiplexers of the operand-fetch stage. The block also keeps a written-since-clear scoreboard and the index of the last committed write, for hazard and debug logic.

## Interface
- REG_SIZE, 32, width of each register and of wr_data
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to index 0 are dropped
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- wr_en  input  1  commit wr_data to register wr_sel on this edge
- wr_sel  input  5  destination register index 0..31
- wr_data  input  REG_SIZE  write value
- clr_written  input  1  clear the written scoreboard
- r0 .. r31  output  REG_SIZE each  current register contents, registered
- written  output  32  bit i set once register i has been written since reset/clear
- last_sel  output  5  index of most recent committed write
- last_valid  output  1  last_sel holds a committed write
- wr_dropped  output  1  one-cycle pulse: previous edge had wr_en with wr_sel=0 and ZERO_REG=1

## Operation
- Decode: wr_sel is one-hot decoded; exactly one register is enabled when wr_en=1, none when wr_en=0. Full 5-bit decode, no default case.
- Commit: on a rising edge with reset=0 and wr_en=1, r[wr_sel] <= wr_data. All other registers hold.
- Zero register: with ZERO_REG=1, r0 is constant 0 and never changes. A write to index 0 does not update r0, written[0], last_sel or last_valid, and pulses wr_dropped for one cycle. With ZERO_REG=0, index 0 behaves like any other register.
- Scoreboard: a committed write sets written[wr_sel]. clr_written=1 clears all bits at the edge. If clr_written and a committed write occur on the same edge, written becomes exactly the one-hot bit of wr_sel; the write wins for that bit.
- last_sel/last_valid: updated only on committed writes; last_valid=1 from then on. clr_written does not affect them.
- Reset, taking priority over everything on the same edge:
  - every r0..r31 = 0
  - written = 0
  - last_sel = 0
  - last_valid = 0
  - wr_dropped = 0
- Reset during an active write: the write is discarded and reset values apply.
- Back-to-back writes to the same index on consecutive edges: each edge commits; the final value is the last one.
- Arithmetic: none. wr_data is stored unmodified.

## Timing
- Write latency: a value committed at edge N appears on r[wr_sel] after edge N, i.e. it is readable through the read mux in cycle N+1.
- No internal write-to-read bypass. A read in the same cycle as a write returns the old value. Forwarding is the pipeline's responsibility.
- written, last_sel, last_valid and wr_dropped update on the same edge as the commit.
- wr_dropped is high for exactly the one cycle after the dropped write.
- All outputs are registered; there is no combinational path from any input to any output.
- Single clock domain. No handshake: a write is always accepted.

## Test plan
- Reset: drive reset=1 for 2 cycles with wr_en=1, wr_sel=5, wr_data=32'hFFFF_FFFF. Required after reset: all r* = 0, written = 0, last_valid = 0, wr_dropped = 0.
- Sweep: write wr_data = 32'hA500_0000 + i to index i for i = 1..31 on consecutive cycles, then hold wr_en=0. Required: each r_i equals its value the cycle after its write; written = 32'hFFFF_FFFE; last_sel = 31.
- Zero register, ZERO_REG=1: write 32'hDEAD_BEEF to index 0. Required: r0 stays 0, wr_dropped pulses for 1 cycle, written[0] = 0, last_sel unchanged. Same test with ZERO_REG=0: r0 = 32'hDEAD_BEEF and written[0] = 1.
- Same-cycle read: write 32'h1234 to r7 while r7 = 32'h5678. Required: in that cycle r7 = 32'h5678; next cycle r7 = 32'h1234.
- Clear collision: with written = 32'h0000_00F0, assert clr_written together with a write to index 3. Required: written = 32'h0000_0008, r3 updated.
- Mid-stream reset: during the sweep, assert reset for 1 cycle at i = 10. Required: the i = 10 write is lost and all registers read 0. The sweep continues from i = 11 afterwards; written = bits 11.. only.

Source files
------------

// File: rtl/reg_bank_32x32_wr.sv
// Write side and storage of the ezRISC register file: 32 x REG_SIZE registers,
// one synchronous write port, written-since-clear scoreboard and last-write tracking.
module reg_bank_32x32_wr #(
    parameter int REG_SIZE = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [4:0]          wr_sel,
    input  logic [REG_SIZE-1:0] wr_data,
    input  logic                clr_written,
    output logic [REG_SIZE-1:0] r0,
    output logic [REG_SIZE-1:0] r1,
    output logic [REG_SIZE-1:0] r2,
    output logic [REG_SIZE-1:0] r3,
    output logic [REG_SIZE-1:0] r4,
    output logic [REG_SIZE-1:0] r5,
    output logic [REG_SIZE-1:0] r6,
    output logic [REG_SIZE-1:0] r7,
    output logic [REG_SIZE-1:0] r8,
    output logic [REG_SIZE-1:0] r9,
    output logic [REG_SIZE-1:0] r10,
    output logic [REG_SIZE-1:0] r11,
    output logic [REG_SIZE-1:0] r12,
    output logic [REG_SIZE-1:0] r13,
    output logic [REG_SIZE-1:0] r14,
    output logic [REG_SIZE-1:0] r15,
    output logic [REG_SIZE-1:0] r16,
    output logic [REG_SIZE-1:0] r17,
    output logic [REG_SIZE-1:0] r18,
    output logic [REG_SIZE-1:0] r19,
    output logic [REG_SIZE-1:0] r20,
    output logic [REG_SIZE-1:0] r21,
    output logic [REG_SIZE-1:0] r22,
    output logic [REG_SIZE-1:0] r23,
    output logic [REG_SIZE-1:0] r24,
    output logic [REG_SIZE-1:0] r25,
    output logic [REG_SIZE-1:0] r26,
    output logic [REG_SIZE-1:0] r27,
    output logic [REG_SIZE-1:0] r28,
    output logic [REG_SIZE-1:0] r29,
    output logic [REG_SIZE-1:0] r30,
    output logic [REG_SIZE-1:0] r31,
    output logic [31:0]         written,
    output logic [4:0]          last_sel,
    output logic                last_valid,
    output logic                wr_dropped
);

    logic [31:0]         wr_dec;
    logic [31:0]         commit;
    logic                drop_now;
    logic [REG_SIZE-1:0] regs [32];

    always_comb begin
        wr_dec = '0;
        for (int i = 0; i < 32; i++) begin
            wr_dec[i] = wr_en && (wr_sel == 5'(i));
        end
    end

    // With a hardwired zero register, an index-0 write is decoded but never commits.
    assign commit   = wr_dec & ~{31'b0, ZERO_REG};
    assign drop_now = wr_dec[0] & ZERO_REG;

    genvar g;
    for (g = 0; g < 32; g++) begin : g_reg
        if (g == 0 && ZERO_REG) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_ff
            logic [REG_SIZE-1:0] q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (commit[g]) begin
                    q <= wr_data;
                end
            end
            assign regs[g] = q;
        end
    end

    // Clear and a same-edge commit: the committed bit survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            written    <= '0;
            last_sel   <= '0;
            last_valid <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            written    <= (clr_written ? 32'b0 : written) | commit;
            wr_dropped <= drop_now;
            if (|commit) begin
                last_sel   <= wr_sel;
                last_valid <= 1'b1;
            end
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];
    assign r16 = regs[16];
    assign r17 = regs[17];
    assign r18 = regs[18];
    assign r19 = regs[19];
    assign r20 = regs[20];
    assign r21 = regs[21];
    assign r22 = regs[22];
    assign r23 = regs[23];
    assign r24 = regs[24];
    assign r25 = regs[25];
    assign r26 = regs[26];
    assign r27 = regs[27];
    assign r28 = regs[28];
    assign r29 = regs[29];
    assign r30 = regs[30];
    assign r31 = regs[31];

endmodule

// File: tb/tb_reg_bank_32x32_wr.sv
// Scoreboard bench for reg_bank_32x32_wr: two instances (ZERO_REG=1 and 0) share stimulus;
// expected values are queued per cycle and checked by a negedge monitor.
module tb_reg_bank_32x32_wr;

    logic        clk = 1'b0;
    logic        reset, wr_en, clr_written;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;

    logic [31:0] ra [32];
    logic [31:0] rb [32];
    logic [31:0] wa, wb;
    logic [4:0]  lsa, lsb;
    logic        lva, lvb, wda, wdb;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int          cyc;
        int          inst;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bank_32x32_wr #(.REG_SIZE(32), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr_written(clr_written),
        .r0(ra[0]),   .r1(ra[1]),   .r2(ra[2]),   .r3(ra[3]),
        .r4(ra[4]),   .r5(ra[5]),   .r6(ra[6]),   .r7(ra[7]),
        .r8(ra[8]),   .r9(ra[9]),   .r10(ra[10]), .r11(ra[11]),
        .r12(ra[12]), .r13(ra[13]), .r14(ra[14]), .r15(ra[15]),
        .r16(ra[16]), .r17(ra[17]), .r18(ra[18]), .r19(ra[19]),
        .r20(ra[20]), .r21(ra[21]), .r22(ra[22]), .r23(ra[23]),
        .r24(ra[24]), .r25(ra[25]), .r26(ra[26]), .r27(ra[27]),
        .r28(ra[28]), .r29(ra[29]), .r30(ra[30]), .r31(ra[31]),
        .written(wa), .last_sel(lsa), .last_valid(lva), .wr_dropped(wda)
    );

    reg_bank_32x32_wr #(.REG_SIZE(32), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr_written(clr_written),
        .r0(rb[0]),   .r1(rb[1]),   .r2(rb[2]),   .r3(rb[3]),
        .r4(rb[4]),   .r5(rb[5]),   .r6(rb[6]),   .r7(rb[7]),
        .r8(rb[8]),   .r9(rb[9]),   .r10(rb[10]), .r11(rb[11]),
        .r12(rb[12]), .r13(rb[13]), .r14(rb[14]), .r15(rb[15]),
        .r16(rb[16]), .r17(rb[17]), .r18(rb[18]), .r19(rb[19]),
        .r20(rb[20]), .r21(rb[21]), .r22(rb[22]), .r23(rb[23]),
        .r24(rb[24]), .r25(rb[25]), .r26(rb[26]), .r27(rb[27]),
        .r28(rb[28]), .r29(rb[29]), .r30(rb[30]), .r31(rb[31]),
        .written(wb), .last_sel(lsb), .last_valid(lvb), .wr_dropped(wdb)
    );

    function automatic logic [31:0] actual(int inst, int kind, int idx);
        case (kind)
            0:       return (inst == 0) ? ra[idx] : rb[idx];
            1:       return (inst == 0) ? wa : wb;
            2:       return (inst == 0) ? {27'b0, lsa} : {27'b0, lsb};
            3:       return (inst == 0) ? {31'b0, lva} : {31'b0, lvb};
            default: return (inst == 0) ? {31'b0, wda} : {31'b0, wdb};
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            0:       return "r";
            1:       return "written";
            2:       return "last_sel";
            3:       return "last_valid";
            default: return "wr_dropped";
        endcase
    endfunction

    // Monitor: DUT state is presented every cycle, so entries due this cycle are popped here.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e   = q.pop_front();
            act = actual(e.inst, e.kind, e.idx);
            total++;
            if (act !== e.val || e.cyc != cyc) begin
                bad++;
                $display("FAIL %s[%0d] inst%0d cyc=%0d (due %0d): got %h want %h",
                         kname(e.kind), e.idx, e.inst, cyc, e.cyc, act, e.val);
            end
        end
    end

    task automatic chk(int inst, int kind, int idx, logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.inst = inst;
        e.kind = kind;
        e.idx  = idx;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic chk_both(int kind, int idx, logic [31:0] v);
        chk(0, kind, idx, v);
        chk(1, kind, idx, v);
    endtask

    task automatic step(bit en, logic [4:0] sel, logic [31:0] d, bit clr, bit rst);
        reset       = rst;
        wr_en       = en;
        wr_sel      = sel;
        wr_data     = d;
        clr_written = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; clr_written = 1'b0;

        // Reset with a write pending: write is discarded
        step(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) chk_both(0, i, 32'h0);
        chk_both(1, 0, 32'h0);
        chk_both(2, 0, 32'h0);
        chk_both(3, 0, 32'h0);
        chk_both(4, 0, 32'h0);
        total++;
        if (wa !== 32'h0 || wb !== 32'h0 || lva !== 1'b0 || lvb !== 1'b0 ||
            wda !== 1'b0 || wdb !== 1'b0) begin
            bad++;
            $display("FAIL direct reset: wa=%h wb=%h lva=%b lvb=%b", wa, wb, lva, lvb);
        end

        // Sweep 1..31
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), 32'hA500_0000 + 32'(i), 1'b0, 1'b0);
            chk_both(0, i, 32'hA500_0000 + 32'(i));
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk_both(1, 0, 32'hFFFF_FFFE);
        chk_both(2, 0, 32'd31);
        chk_both(3, 0, 32'd1);
        chk_both(0, 1, 32'hA500_0001);
        chk_both(0, 31, 32'hA500_001F);
        total++;
        if (wa !== 32'hFFFF_FFFE || lsa !== 5'd31 || lsb !== 5'd31) begin
            bad++;
            $display("FAIL direct sweep: wa=%h lsa=%0d lsb=%0d", wa, lsa, lsb);
        end

        // Zero register
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk(0, 0, 0, 32'h0);
        chk(0, 4, 0, 32'd1);
        chk(0, 1, 0, 32'hFFFF_FFFE);
        chk(0, 2, 0, 32'd31);
        chk(1, 0, 0, 32'hDEAD_BEEF);
        chk(1, 4, 0, 32'd0);
        chk(1, 1, 0, 32'hFFFF_FFFF);
        chk(1, 2, 0, 32'd0);
        total++;
        if (wda !== 1'b1 || ra[0] !== 32'h0 || wa[0] !== 1'b0) begin
            bad++;
            $display("FAIL direct zero a: wda=%b r0=%h", wda, ra[0]);
        end
        total++;
        if (rb[0] !== 32'hDEAD_BEEF || wb[0] !== 1'b1 || wdb !== 1'b0) begin
            bad++;
            $display("FAIL direct zero b: r0=%h wb=%h", rb[0], wb);
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk(0, 4, 0, 32'd0);
        chk(0, 0, 0, 32'h0);
        total++;
        if (wda !== 1'b0) begin
            bad++;
            $display("FAIL direct wr_dropped not one cycle");
        end

        // Same-cycle read returns old value
        step(1'b1, 5'd7, 32'h5678, 1'b0, 1'b0);
        chk_both(0, 7, 32'h5678);
        wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'h1234;
        chk_both(0, 7, 32'h5678);
        #1;
        total++;
        if (ra[7] !== 32'h5678 || rb[7] !== 32'h5678) begin
            bad++;
            $display("FAIL direct same-cycle read: %h %h", ra[7], rb[7]);
        end
        step(1'b1, 5'd7, 32'h1234, 1'b0, 1'b0);
        chk_both(0, 7, 32'h1234);
        total++;
        if (ra[7] !== 32'h1234) begin
            bad++;
            $display("FAIL direct r7 after write: %h", ra[7]);
        end

        // Back-to-back writes to one index
        step(1'b1, 5'd9, 32'h1111_1111, 1'b0, 1'b0);
        chk_both(0, 9, 32'h1111_1111);
        step(1'b1, 5'd9, 32'h2222_2222, 1'b0, 1'b0);
        chk_both(0, 9, 32'h2222_2222);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk_both(0, 9, 32'h2222_2222);

        // Clear alone, then clear colliding with a write
        step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk_both(1, 0, 32'h0);
        chk_both(2, 0, 32'd9);
        chk_both(3, 0, 32'd1);
        for (int i = 4; i < 8; i++) step(1'b1, 5'(i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        chk_both(1, 0, 32'h0000_00F0);
        step(1'b1, 5'd3, 32'h3333_3333, 1'b1, 1'b0);
        chk_both(1, 0, 32'h0000_0008);
        chk_both(0, 3, 32'h3333_3333);
        chk_both(0, 4, 32'hC000_0004);
        chk_both(2, 0, 32'd3);
        total++;
        if (wa !== 32'h0000_0008 || wb !== 32'h0000_0008 || ra[3] !== 32'h3333_3333) begin
            bad++;
            $display("FAIL direct clear collision: wa=%h wb=%h r3=%h", wa, wb, ra[3]);
        end

        // Sweep with a reset at i=10
        for (int i = 1; i < 32; i++) begin
            if (i == 10) begin
                step(1'b1, 5'd10, 32'hA500_000A, 1'b0, 1'b1);
                for (int j = 0; j < 32; j++) chk_both(0, j, 32'h0);
                chk_both(1, 0, 32'h0);
                chk_both(3, 0, 32'd0);
                chk_both(4, 0, 32'd0);
                total++;
                if (ra[10] !== 32'h0 || rb[9] !== 32'h0 || wa !== 32'h0) begin
                    bad++;
                    $display("FAIL direct mid reset: r10=%h r9=%h wa=%h", ra[10], rb[9], wa);
                end
            end else begin
                step(1'b1, 5'(i), 32'hA500_0000 + 32'(i), 1'b0, 1'b0);
                chk_both(0, i, 32'hA500_0000 + 32'(i));
            end
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk_both(1, 0, 32'hFFFF_F800);
        for (int j = 0; j < 11; j++) chk_both(0, j, 32'h0);
        chk_both(0, 11, 32'hA500_000B);
        chk_both(0, 31, 32'hA500_001F);
        chk_both(2, 0, 32'd31);
        chk_both(3, 0, 32'd1);
        total++;
        if (wa !== 32'hFFFF_F800 || wb !== 32'hFFFF_F800) begin
            bad++;
            $display("FAIL direct final written: wa=%h wb=%h", wa, wb);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0 && total > 0) $display("PASS");
        else $display("FAIL: %0d of %0d checks failed", bad, total);
        $finish;
    end

endmodule
